// File: rtl/uart_core.sv
// UART core: free-running x16 tick, TX serializer, 2-flop synchronized RX with mid-bit sampling.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; the default build uses one holding register.
module uart_core #(
    parameter int CLK_DIV     = 326,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    localparam logic [7:0] DMASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic       PAR_ODD = (PARITY_MODE == 2);
    localparam logic [2:0] LAST_D  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_S  = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} st_t;
    typedef struct packed { logic perr; logic ferr; logic [7:0] data; } rx_ent_t;

    logic [15:0] tick_cnt;
    logic        tick;
    assign tick = (tick_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + 16'd1;

    // ---------------- TX ----------------
    st_t        tx_st, tx_st_n;
    logic [3:0] tx_sub, tx_sub_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [7:0] tx_byte, tx_byte_n;
    logic       tx_arm, tx_arm_n, txd_n;

    assign tx_ready = (tx_st == IDLE);

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) begin
            tx_st <= IDLE; tx_sub <= '0; tx_bit <= '0; tx_byte <= '0; tx_arm <= 1'b0; uart_txd <= 1'b1;
        end else begin
            tx_st <= tx_st_n; tx_sub <= tx_sub_n; tx_bit <= tx_bit_n; tx_byte <= tx_byte_n;
            tx_arm <= tx_arm_n; uart_txd <= txd_n;
        end

    // tx_arm holds the line high after acceptance until the next tick starts the start bit
    always_comb begin
        tx_st_n = tx_st; tx_sub_n = tx_sub; tx_bit_n = tx_bit; tx_byte_n = tx_byte;
        tx_arm_n = tx_arm; txd_n = uart_txd;
        case (tx_st)
            IDLE: begin
                txd_n = 1'b1;
                if (tx_valid) begin
                    tx_byte_n = tx_data & DMASK;
                    tx_arm_n  = 1'b0;
                    tx_st_n   = START;
                end
            end
            START: if (tick) begin
                if (!tx_arm) begin
                    tx_arm_n = 1'b1; tx_sub_n = '0; txd_n = 1'b0;
                end else if (tx_sub == 4'd15) begin
                    tx_sub_n = '0; tx_bit_n = '0; txd_n = tx_byte[0]; tx_st_n = DATA;
                end else tx_sub_n = tx_sub + 4'd1;
            end
            DATA: if (tick) begin
                if (tx_sub == 4'd15) begin
                    tx_sub_n = '0;
                    if (tx_bit != LAST_D) begin
                        tx_bit_n = tx_bit + 3'd1;
                        txd_n    = tx_byte[tx_bit + 3'd1];
                    end else if (PARITY_MODE != 0) begin
                        txd_n   = ^tx_byte ^ PAR_ODD;
                        tx_st_n = PARITY;
                    end else begin
                        txd_n = 1'b1; tx_bit_n = '0; tx_st_n = STOP;
                    end
                end else tx_sub_n = tx_sub + 4'd1;
            end
            PARITY: if (tick) begin
                if (tx_sub == 4'd15) begin
                    tx_sub_n = '0; txd_n = 1'b1; tx_bit_n = '0; tx_st_n = STOP;
                end else tx_sub_n = tx_sub + 4'd1;
            end
            STOP: if (tick) begin
                if (tx_sub == 4'd15) begin
                    tx_sub_n = '0;
                    if (tx_bit == LAST_S) tx_st_n = IDLE;
                    else                  tx_bit_n = tx_bit + 3'd1;
                end else tx_sub_n = tx_sub + 4'd1;
            end
            default: tx_st_n = IDLE;
        endcase
    end

    // ---------------- RX ----------------
    logic       rxd_s1, rxd_s2, rxd_d;
    st_t        rx_st, rx_st_n;
    logic [3:0] rx_sub, rx_sub_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_byte, rx_byte_n;
    logic       rx_par, rx_par_n;
    logic       push;
    rx_ent_t    push_ent;

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) begin
            rxd_s1 <= 1'b1; rxd_s2 <= 1'b1; rxd_d <= 1'b1;
            rx_st <= IDLE; rx_sub <= '0; rx_bit <= '0; rx_byte <= '0; rx_par <= 1'b0;
        end else begin
            rxd_s1 <= uart_rxd; rxd_s2 <= rxd_s1; rxd_d <= rxd_s2;
            rx_st <= rx_st_n; rx_sub <= rx_sub_n; rx_bit <= rx_bit_n;
            rx_byte <= rx_byte_n; rx_par <= rx_par_n;
        end

    always_comb begin
        rx_st_n = rx_st; rx_sub_n = rx_sub; rx_bit_n = rx_bit; rx_byte_n = rx_byte; rx_par_n = rx_par;
        push          = 1'b0;
        push_ent.perr = (PARITY_MODE != 0) && (^rx_byte ^ rx_par ^ PAR_ODD);
        push_ent.ferr = ~rxd_s2;
        push_ent.data = rx_byte;
        case (rx_st)
            IDLE: if (rxd_d && !rxd_s2) begin
                rx_st_n = START; rx_sub_n = '0; rx_byte_n = '0;
            end
            START: if (tick) begin
                if (rx_sub == 4'd7) begin
                    if (rxd_s2) rx_st_n = IDLE;
                    else begin rx_sub_n = '0; rx_bit_n = '0; rx_st_n = DATA; end
                end else rx_sub_n = rx_sub + 4'd1;
            end
            DATA: if (tick) begin
                if (rx_sub == 4'd15) begin
                    rx_sub_n = '0;
                    rx_byte_n[rx_bit] = rxd_s2;
                    if (rx_bit == LAST_D) rx_st_n = (PARITY_MODE != 0) ? PARITY : STOP;
                    else                  rx_bit_n = rx_bit + 3'd1;
                end else rx_sub_n = rx_sub + 4'd1;
            end
            PARITY: if (tick) begin
                if (rx_sub == 4'd15) begin
                    rx_sub_n = '0; rx_par_n = rxd_s2; rx_st_n = STOP;
                end else rx_sub_n = rx_sub + 4'd1;
            end
            STOP: if (tick) begin
                if (rx_sub == 4'd15) begin
                    rx_sub_n = '0; push = 1'b1; rx_st_n = IDLE;
                end else rx_sub_n = rx_sub + 4'd1;
            end
            default: rx_st_n = IDLE;
        endcase
    end

    // ---------------- RX buffering ----------------
    logic    pop, wr_en, drop;
    rx_ent_t head;
    assign pop  = rx_valid && rx_ready;
    assign drop = push && !wr_en;

`ifdef UART_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    rx_ent_t       mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full;

    assign full     = (32'(count) == FIFO_DEPTH);
    assign wr_en    = push && (!full || pop);
    assign rx_valid = (count != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge sysclk)
        if (wr_en) mem[wr_ptr] <= push_ent;

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        end
`else
    rx_ent_t hold;
    logic    hold_vld;

    assign wr_en    = push && (!hold_vld || pop);
    assign rx_valid = hold_vld;
    assign head     = hold;

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) begin
            hold <= '0; hold_vld <= 1'b0;
        end else if (wr_en) begin
            hold <= push_ent; hold_vld <= 1'b1;
        end else if (pop) hold_vld <= 1'b0;
`endif

    assign rx_data    = rx_valid ? head.data : 8'h00;
    assign parity_err = rx_valid & head.perr;
    assign frame_err  = rx_valid & head.ferr;

    always_ff @(posedge sysclk or negedge reset_n)
        if (!reset_n) overrun <= 1'b0;
        else          overrun <= drop;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: u0 is 8N1, u1 is 8E1, both CLK_DIV=4 (64 sysclk per bit), FIFO_DEPTH=4.
module tb_uart_core;
    localparam int BIT = 64;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic sysclk = 1'b0, reset_n = 1'b0;
    always #5 sysclk = ~sysclk;

    logic [7:0] tx_data0 = 8'h00, rx_data0, tx_data1 = 8'h00, rx_data1;
    logic tx_valid0 = 1'b0, tx_ready0, rx_valid0, rx_ready0 = 1'b0, perr0, ferr0, ov0, txd0, rxd0;
    logic tx_valid1 = 1'b0, tx_ready1, rx_valid1, rx_ready1 = 1'b0, perr1, ferr1, ov1, txd1;
    logic lb = 1'b0, drv0 = 1'b1, drv1 = 1'b1;
    assign rxd0 = lb ? txd0 : drv0;

    int total = 0, bad = 0, ov_cnt = 0;
    always @(negedge sysclk) if (ov0) ov_cnt++;

    uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .sysclk(sysclk), .reset_n(reset_n), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ov0), .uart_rxd(rxd0), .uart_txd(txd0));

    uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .sysclk(sysclk), .reset_n(reset_n), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .parity_err(perr1),
        .frame_err(ferr1), .overrun(ov1), .uart_rxd(drv1), .uart_txd(txd1));

    // scoreboard of expected RX entries: {perr, ferr, data}
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [7:0] b);
        int n = 0;
        while (!tx_ready0 && n < 3000) begin @(negedge sysclk); n++; end
        chk("tx_ready_before_send", 32'(tx_ready0), 32'd1);
        tx_data0 = b; tx_valid0 = 1'b1;
        @(negedge sysclk);
        tx_valid0 = 1'b0;
        chk("tx_ready_after_accept", 32'(tx_ready0), 32'd0);
    endtask

    task automatic drive(input bit u, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (u) drv1 = bits[i]; else drv0 = bits[i];
            repeat (BIT) @(negedge sysclk);
        end
        if (u) drv1 = 1'b1; else drv0 = 1'b1;
    endtask

    task automatic get_rx(input bit u, input string tag);
        int n = 0;
        logic [9:0] e;
        e = exp_q.pop_front();
        while (!(u ? rx_valid1 : rx_valid0) && n < 2000) begin @(negedge sysclk); n++; end
        chk({tag, "_valid"}, 32'(u ? rx_valid1 : rx_valid0), 32'd1);
        chk({tag, "_data"},  32'(u ? rx_data1 : rx_data0), 32'(e[7:0]));
        chk({tag, "_ferr"},  32'(u ? ferr1 : ferr0), 32'(e[8]));
        chk({tag, "_perr"},  32'(u ? perr1 : perr0), 32'(e[9]));
        if (u) rx_ready1 = 1'b1; else rx_ready0 = 1'b1;
        @(negedge sysclk);
        rx_ready0 = 1'b0; rx_ready1 = 1'b0;
    endtask

    bit a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [7:0] b, sent[5];
    logic p, corrupt, seen;
    int cnt, n, ov_base;

    initial begin
        repeat (3) @(negedge sysclk);
        chk("rst_txd", 32'(txd0), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready0), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
        chk("rst_rx_data", 32'(rx_data0), 32'd0);
        chk("rst_perr", 32'(perr0), 32'd0);
        chk("rst_ferr", 32'(ferr0), 32'd0);
        chk("rst_overrun", 32'(ov0), 32'd0);
        chk("rst_rx_valid1", 32'(rx_valid1), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge sysclk);

        // 0xA5 on the wire, 64 cycles per bit, 640 cycles start-to-ready
        send0(8'hA5);
        n = 0;
        while (txd0 && n < 100) begin @(negedge sysclk); n++; end
        chk("tx_start_seen", 32'(txd0), 32'd0);
        cnt = 0;
        while (!tx_ready0 && cnt < 1000) begin
            if (cnt % BIT == BIT / 2) chk($sformatf("tx_a5_bit%0d", cnt / BIT), 32'(txd0), 32'(a5_bits[cnt / BIT]));
            @(negedge sysclk); cnt++;
        end
        chk("tx_frame_cycles", 32'(cnt), 32'd640);
        chk("txd_idle_after", 32'(txd0), 32'd1);

        // loopback: fixed corners then random bytes
        lb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h5A : 8'($urandom_range(0, 255));
            exp_q.push_back({2'b00, b});
            send0(b);
            get_rx(1'b0, $sformatf("loop%0d", i));
        end
        n = 0;
        while (!tx_ready0 && n < 2000) begin @(negedge sysclk); n++; end
        repeat (BIT) @(negedge sysclk);
        lb = 1'b0;

        // even parity: 0x07 with parity bit 0 is a mismatch
        exp_q.push_back({1'b1, 1'b0, 8'h07});
        drive(1'b1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        get_rx(1'b1, "par07");
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            corrupt = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            p = 1'($countones(b) % 2) ^ corrupt;
            exp_q.push_back({corrupt, 1'b0, b});
            drive(1'b1, {5'b0, 1'b1, p, b, 1'b0}, 11);
            get_rx(1'b1, $sformatf("par_rand%0d", i));
        end

        // stop bit low -> frame error, byte still delivered
        b = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, 1'b1, b});
        drive(1'b0, {6'b0, 1'b0, b, 1'b0}, 10);
        get_rx(1'b0, "frame_err");

        // 4-tick low glitch must be rejected
        repeat (BIT) @(negedge sysclk);
        drv0 = 1'b0;
        repeat (16) @(negedge sysclk);
        drv0 = 1'b1;
        seen = 1'b0;
        repeat (1500) begin @(negedge sysclk); seen |= rx_valid0; end
        chk("glitch_no_rx", 32'(seen), 32'd0);

        // five bytes with rx_ready held low
        ov_base = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            drive(1'b0, {6'b0, 1'b1, sent[i], 1'b0}, 10);
        end
        repeat (10) @(negedge sysclk);
        chk("overrun_pulses", 32'(ov_cnt - ov_base), 32'(5 - CAP));
        for (int i = 0; i < CAP; i++) begin
            exp_q.push_back({2'b00, sent[i]});
            get_rx(1'b0, $sformatf("ovr_pop%0d", i));
        end
        repeat (3) @(negedge sysclk);
        chk("rx_empty_after_pops", 32'(rx_valid0), 32'd0);

        // reset mid-TX (u0 looped back) and mid-RX (u1 line low)
        lb = 1'b1;
        send0(8'h3C);
        drv1 = 1'b0;
        repeat (300) @(negedge sysclk);
        reset_n = 1'b0;
        #1;
        chk("midrst_txd", 32'(txd0), 32'd1);
        chk("midrst_tx_ready", 32'(tx_ready0), 32'd1);
        chk("midrst_rx_valid0", 32'(rx_valid0), 32'd0);
        chk("midrst_rx_valid1", 32'(rx_valid1), 32'd0);
        drv1 = 1'b1;
        repeat (3) @(negedge sysclk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (1500) begin @(negedge sysclk); seen |= rx_valid0 | rx_valid1; end
        chk("no_rx_after_reset", 32'(seen), 32'd0);
        chk("txd_idle_after_reset", 32'(txd0), 32'd1);
        chk("tx_ready_after_reset", 32'(tx_ready0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL declare parameter CLK_DIV, default 326, meaning sysclk cycles per x16-oversample tick (legal range 2..65535).
REQ-002 The block SHALL declare parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-003 The block SHALL declare parameter PARITY_MODE, default 0, meaning parity setting (0 none, 1 even, 2 odd).
REQ-004 The block SHALL declare parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-005 The block SHALL declare parameter FIFO_DEPTH, default 16, meaning RX FIFO entries (power of two, 2..256).
REQ-006 Port sysclk SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-007 Port reset_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-008 Port tx_data SHALL be an input, 8 bits wide: the byte to send; bits above DATA_BITS-1 are ignored.
REQ-009 Port tx_valid SHALL be an input, 1 bit wide: the TX request.
REQ-010 Port tx_ready SHALL be an output, 1 bit wide: high when the transmitter can accept a byte.
REQ-011 Port rx_data SHALL be an output, 8 bits wide: the received byte, zero-extended above DATA_BITS.
REQ-012 Port rx_valid SHALL be an output, 1 bit wide, and port rx_ready SHALL be an input, 1 bit wide: together they form the RX valid/ready handshake.
REQ-013 Ports parity_err and frame_err SHALL be outputs, 1 bit wide each: error status qualified by rx_valid and belonging to the rx_data byte.
REQ-014 Port overrun SHALL be an output, 1 bit wide: a one-cycle pulse when a received byte is dropped.
REQ-015 Port uart_rxd SHALL be an input, 1 bit wide: the serial line in, asynchronous.
REQ-016 Port uart_txd SHALL be an output, 1 bit wide: the serial line out, idle high.

Function
REQ-017 Tick generator SHALL count 0..CLK_DIV-1 and assert a one-sysclk tick on wrap; it SHALL free-run after reset.
REQ-018 Frame format SHALL be: start(0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits(1); each bit lasts 16 ticks.
REQ-019 Parity SHALL be XOR of the data bits for even, and its inverse for odd.
REQ-020 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_MODE=0.
REQ-021 tx_ready SHALL be 1 only in IDLE; a transfer occurs when tx_valid&&tx_ready at a sysclk edge, tx_data is captured, and tx_ready is 0 the next cycle.
REQ-022 uart_txd SHALL go low on the first tick after acceptance and return to IDLE with tx_ready=1 after the last stop bit completes; back-to-back requests SHALL add no extra idle bit.
REQ-023 uart_rxd SHALL pass through a 2-flop synchronizer before use.
REQ-024 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP: IDLE leaves on a synchronized 1->0 edge; START re-samples at tick 8 and returns to IDLE if the line is high (glitch reject).
REQ-025 In DATA, PARITY and STOP, RX SHALL sample at tick 8 of each bit.
REQ-026 RX SHALL sample only the first stop bit; frame_err SHALL be set if it is 0.
REQ-027 parity_err SHALL be set on a parity mismatch and SHALL always be 0 when PARITY_MODE=0.
REQ-028 After the mid-sample of the stop bit, RX SHALL return to IDLE and be able to detect a new start edge immediately.
REQ-029 A completed byte SHALL be stored with its flags in the same cycle the stop bit is sampled; if no space is available, the byte SHALL be discarded and overrun pulsed for 1 cycle.
REQ-030 Frames with errors SHALL still be delivered, with their flags set.
REQ-031 rx_valid, rx_data and the flags SHALL be stable while rx_valid&&!rx_ready; an entry pops on rx_valid&&rx_ready.

Reset
REQ-032 While reset_n=0, uart_txd SHALL be 1, tx_ready 1, rx_valid 0, rx_data 0, parity_err 0, frame_err 0, overrun 0, both FSMs IDLE, the tick counter 0 and the FIFO empty.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; a partial byte SHALL never be delivered.

Configuration
REQ-034 With UART_RX_FIFO_EN defined, received bytes SHALL enter a FIFO_DEPTH-entry FIFO (10 bits per entry: data plus 2 flags).
REQ-035 With UART_RX_FIFO_EN defined, pushing and popping in the same cycle while full SHALL succeed without overrun, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 Without UART_RX_FIFO_EN, the block SHALL use a single holding register: a new byte arriving while rx_valid=1 and rx_ready=0 SHALL be dropped with overrun; one arriving in the same cycle as a pop SHALL be accepted.

Verification
REQ-037 The bench SHALL cover: CLK_DIV=4, 8N1, send 0xA5 -> uart_txd shows 0,1,0,1,0,0,1,0,1,1 with each bit 64 sysclk, and tx_ready returns to 1 after 640 cycles.
REQ-038 The bench SHALL cover: loop uart_txd to uart_rxd and send 0x00, 0xFF, 0x5A -> rx_data shows the same bytes in order with no flags set.
REQ-039 The bench SHALL cover: PARITY_MODE=1, drive 0x07 with parity bit 0 -> rx_valid with parity_err=1 and rx_data=0x07.
REQ-040 The bench SHALL cover: drive a frame with stop bit 0 -> frame_err=1; drive a 4-tick low glitch -> no rx_valid.
REQ-041 The bench SHALL cover: rx_ready held 0 with FIFO_EN and depth 4, drive 5 bytes -> 4 stored, overrun pulses once, and pops return the first 4 bytes.
REQ-042 The bench SHALL cover: reset_n pulsed low mid-TX and mid-RX -> uart_txd=1 and tx_ready=1 immediately, and no rx_valid afterwards.
